// File: rtl/bcp_clause_eval_if.sv
// Handshake, assignment and clause-memory bundle for bcp_clause_eval.
// The slave modport is the evaluator; master is the requester plus memory side.
interface bcp_clause_eval_if #(
    parameter int NVARS = 64
);
    logic             start;
    logic [7:0]       clause_addr;
    logic [NVARS-1:0] assign_def;
    logic [NVARS-1:0] assign_val;
    logic [7:0]       mem_dout;
    logic             mem_en;
    logic             mem_rw;
    logic [7:0]       mem_addr;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [7:0]       unit_lit;

    modport slave (
        input  start, clause_addr, assign_def, assign_val, mem_dout,
        output mem_en, mem_rw, mem_addr, busy, done, status, unit_lit
    );

    modport master (
        output start, clause_addr, assign_def, assign_val, mem_dout,
        input  mem_en, mem_rw, mem_addr, busy, done, status, unit_lit
    );
endinterface

// File: rtl/bcp_clause_eval.sv
// Walks one clause in clause memory and classifies it as SAT/UNIT/CONFLICT/UNRESOLVED.
// Define BCP_EARLY_EXIT_EN to stop the scan at the first true literal.
module bcp_clause_eval #(
    parameter int NVARS   = 64,
    parameter int MAX_LEN = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    bcp_clause_eval_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, EVAL} state_t;

    localparam logic [1:0] ST_UNRES = 2'b00;
    localparam logic [1:0] ST_SAT   = 2'b01;
    localparam logic [1:0] ST_UNIT  = 2'b10;
    localparam logic [1:0] ST_CONF  = 2'b11;
    localparam logic [7:0] LEN_LIM  = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] words_q, words_d;
    logic [1:0] cnt_q, cnt_d;
    logic       sat_q, sat_d;
    logic [7:0] lit_q, lit_d;
    logic       done_q, done_d;
    logic [1:0] status_q, status_d;
    logic [7:0] unit_q, unit_d;

    logic [5:0] lit_var;
    logic       lit_term, lit_def, lit_true, finish;

    assign lit_var  = bus.mem_dout[5:0];
    assign lit_term = (lit_var == 6'd0);
    assign lit_def  = bus.assign_def[lit_var];
    assign lit_true = lit_def & (bus.assign_val[lit_var] ^ bus.mem_dout[6]);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        words_d  = words_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        lit_d    = lit_q;
        done_d   = 1'b0;
        status_d = status_q;
        unit_d   = unit_q;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ptr_d   = bus.clause_addr;
                    words_d = 8'd0;
                    cnt_d   = 2'd0;
                    sat_d   = 1'b0;
                    lit_d   = 8'h00;
                    state_d = READ;
                end
            end
            READ: state_d = EVAL;
            EVAL: begin
                if (lit_term) begin
                    finish = 1'b1;
                end else begin
                    words_d = words_q + 8'd1;
                    if (lit_true) begin
                        sat_d = 1'b1;
                    end else if (!lit_def) begin
                        // Only the first unassigned literal can become the implied one.
                        if (cnt_q == 2'd0) lit_d = bus.mem_dout;
                        if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
                    end
                    if (words_d == LEN_LIM) finish = 1'b1;
`ifdef BCP_EARLY_EXIT_EN
                    if (lit_true) finish = 1'b1;
`endif
                end
                if (finish) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    unit_d  = 8'h00;
                    if (sat_d)              status_d = ST_SAT;
                    else if (cnt_d == 2'd1) begin
                        status_d = ST_UNIT;
                        unit_d   = lit_d;
                    end
                    else if (cnt_d == 2'd2) status_d = ST_UNRES;
                    else                    status_d = ST_CONF;
                end else begin
                    ptr_d   = ptr_q + 8'd1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            ptr_q    <= 8'h00;
            words_q  <= 8'd0;
            cnt_q    <= 2'd0;
            sat_q    <= 1'b0;
            lit_q    <= 8'h00;
            done_q   <= 1'b0;
            status_q <= ST_UNRES;
            unit_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            words_q  <= words_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            lit_q    <= lit_d;
            done_q   <= done_d;
            status_q <= status_d;
            unit_q   <= unit_d;
        end
    end

    assign bus.mem_en   = (state_q == READ);
    assign bus.mem_rw   = 1'b1;
    assign bus.mem_addr = ptr_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.status   = status_q;
    assign bus.unit_lit = unit_q;
endmodule

// File: tb/tb_bcp_clause_eval.sv
// Directed bench for bcp_clause_eval: one task per scenario, inline checks.
module tb_bcp_clause_eval;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem  [256];
    logic [7:0] alog [256];
    int         alen = 0;

`ifdef BCP_EARLY_EXIT_EN
    localparam int SAT_CYC = 2;
`else
    localparam int SAT_CYC = 6;
`endif

    always #5 clk = ~clk;

    bcp_clause_eval_if #(.NVARS(64)) ifc ();

    bcp_clause_eval #(.NVARS(64), .MAX_LEN(16)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (ifc)
    );

    // Clause memory with one-cycle read latency; also logs every read address.
    always @(posedge clk) begin
        if (ifc.mem_en) begin
            ifc.mem_dout    <= mem[ifc.mem_addr];
            alog[alen % 256] <= ifc.mem_addr;
            alen            <= alen + 1;
        end
    end

    task automatic start_clause(input logic [7:0] addr);
        @(negedge clk);
        ifc.start       = 1'b1;
        ifc.clause_addr = addr;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (ifc.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic load_unit_clause();
        mem[8'h04] = 8'h03; mem[8'h05] = 8'h45; mem[8'h06] = 8'h00;
        ifc.assign_def = '0; ifc.assign_val = '0;
        ifc.assign_def[3] = 1'b1; ifc.assign_val[3] = 1'b0;
    endtask

    task automatic load_sat_clause();
        mem[8'h10] = 8'h02; mem[8'h11] = 8'h07; mem[8'h12] = 8'h00;
        ifc.assign_def = '0; ifc.assign_val = '0;
        ifc.assign_def[2] = 1'b1; ifc.assign_val[2] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ifc.mem_en !== 1'b0)    begin errors++; $display("FAIL reset_mem_en: got %b exp 0", ifc.mem_en); end
        checks++; if (ifc.mem_rw !== 1'b1)    begin errors++; $display("FAIL reset_mem_rw: got %b exp 1", ifc.mem_rw); end
        checks++; if (ifc.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h exp 00", ifc.mem_addr); end
        checks++; if (ifc.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b exp 0", ifc.busy); end
        checks++; if (ifc.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b exp 0", ifc.done); end
        checks++; if (ifc.status !== 2'b00)   begin errors++; $display("FAIL reset_status: got %b exp 00", ifc.status); end
        checks++; if (ifc.unit_lit !== 8'h00) begin errors++; $display("FAIL reset_unit_lit: got %h exp 00", ifc.unit_lit); end
        rst = 1'b0;
    endtask

    task automatic test_unit();
        int n, base;
        load_unit_clause();
        base = alen;
        start_clause(8'h04);
        checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL unit_busy_e0: got %b exp 1", ifc.busy); end
        wait_done(n);
        checks++; if (n != 6)                 begin errors++; $display("FAIL unit_latency: got %0d exp 6", n); end
        checks++; if (ifc.status !== 2'b10)   begin errors++; $display("FAIL unit_status: got %b exp 10", ifc.status); end
        checks++; if (ifc.unit_lit !== 8'h45) begin errors++; $display("FAIL unit_lit: got %h exp 45", ifc.unit_lit); end
        checks++; if (ifc.busy !== 1'b0)      begin errors++; $display("FAIL unit_busy_done: got %b exp 0", ifc.busy); end
        checks++; if (alen - base != 3)       begin errors++; $display("FAIL unit_nreads: got %0d exp 3", alen - base); end
        checks++; if (alog[base % 256] !== 8'h04 || alog[(base + 1) % 256] !== 8'h05 || alog[(base + 2) % 256] !== 8'h06)
            begin errors++; $display("FAIL unit_addr_seq: got %h %h %h exp 04 05 06",
                alog[base % 256], alog[(base + 1) % 256], alog[(base + 2) % 256]); end
        @(posedge clk); #1;
        checks++; if (ifc.done !== 1'b0)      begin errors++; $display("FAIL unit_done_pulse: got %b exp 0", ifc.done); end
        checks++; if (ifc.status !== 2'b10 || ifc.unit_lit !== 8'h45)
            begin errors++; $display("FAIL unit_hold: got %b/%h exp 10/45", ifc.status, ifc.unit_lit); end
    endtask

    task automatic test_sat();
        int n;
        load_sat_clause();
        start_clause(8'h10);
        checks++; if (ifc.status !== 2'b10) begin errors++; $display("FAIL sat_status_not_cleared: got %b exp 10", ifc.status); end
        wait_done(n);
        checks++; if (n != SAT_CYC)           begin errors++; $display("FAIL sat_latency: got %0d exp %0d", n, SAT_CYC); end
        checks++; if (ifc.status !== 2'b01)   begin errors++; $display("FAIL sat_status: got %b exp 01", ifc.status); end
        checks++; if (ifc.unit_lit !== 8'h00) begin errors++; $display("FAIL sat_unit_lit: got %h exp 00", ifc.unit_lit); end
    endtask

    task automatic test_conflict();
        int n;
        mem[8'h20] = 8'h00;
        ifc.assign_def = '0; ifc.assign_val = '0;
        start_clause(8'h20);
        wait_done(n);
        checks++; if (n != 2)               begin errors++; $display("FAIL empty_latency: got %0d exp 2", n); end
        checks++; if (ifc.status !== 2'b11) begin errors++; $display("FAIL empty_status: got %b exp 11", ifc.status); end
        mem[8'h30] = 8'h41; mem[8'h31] = 8'h02; mem[8'h32] = 8'h00;
        ifc.assign_def[1] = 1'b1; ifc.assign_val[1] = 1'b1;
        ifc.assign_def[2] = 1'b1; ifc.assign_val[2] = 1'b0;
        start_clause(8'h30);
        wait_done(n);
        checks++; if (n != 6)                 begin errors++; $display("FAIL conf_latency: got %0d exp 6", n); end
        checks++; if (ifc.status !== 2'b11)   begin errors++; $display("FAIL conf_status: got %b exp 11", ifc.status); end
        checks++; if (ifc.unit_lit !== 8'h00) begin errors++; $display("FAIL conf_unit_lit: got %h exp 00", ifc.unit_lit); end
    endtask

    task automatic test_wrap_maxlen();
        int n, base, bad;
        logic [7:0] a;
        ifc.assign_def = '0; ifc.assign_val = '0;
        for (int i = 0; i < 16; i++) begin
            a = 8'hFE + 8'(i);
            mem[a] = 8'h08 + 8'(i);
        end
        mem[8'h0E] = 8'h00;
        base = alen;
        start_clause(8'hFE);
        wait_done(n);
        checks++; if (n != 32)                begin errors++; $display("FAIL wrap_latency: got %0d exp 32", n); end
        checks++; if (ifc.status !== 2'b00)   begin errors++; $display("FAIL wrap_status: got %b exp 00", ifc.status); end
        checks++; if (ifc.unit_lit !== 8'h00) begin errors++; $display("FAIL wrap_unit_lit: got %h exp 00", ifc.unit_lit); end
        checks++; if (alen - base != 16)      begin errors++; $display("FAIL wrap_nreads: got %0d exp 16", alen - base); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            a = 8'hFE + 8'(i);
            if (alog[(base + i) % 256] !== a) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_addr_seq: got %0d wrong addresses exp 0", bad); end
    endtask

    task automatic test_back_to_back();
        int n, dones;
        load_unit_clause();
        mem[8'h10] = 8'h02; mem[8'h11] = 8'h07; mem[8'h12] = 8'h00;
        ifc.assign_def[2] = 1'b1; ifc.assign_val[2] = 1'b1;
        start_clause(8'h04);
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.clause_addr = 8'h20;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        dones = 0; n = -1;
        for (int i = 3; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ifc.done === 1'b1) begin
                dones++;
                if (n < 0) begin
                    n = i;
                    ifc.start = 1'b1; ifc.clause_addr = 8'h10;
                    break;
                end
            end
        end
        checks++; if (n != 6)                 begin errors++; $display("FAIL b2b_first_latency: got %0d exp 6", n); end
        checks++; if (ifc.status !== 2'b10 || ifc.unit_lit !== 8'h45)
            begin errors++; $display("FAIL b2b_first_result: got %b/%h exp 10/45", ifc.status, ifc.unit_lit); end
        @(posedge clk); #1;
        ifc.start = 1'b0;
        checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b exp 1", ifc.busy); end
        wait_done(n);
        checks++; if (n != SAT_CYC)         begin errors++; $display("FAIL b2b_second_latency: got %0d exp %0d", n, SAT_CYC); end
        checks++; if (ifc.status !== 2'b01) begin errors++; $display("FAIL b2b_second_status: got %b exp 01", ifc.status); end
        dones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ifc.done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL b2b_extra_done: got %0d exp 0", dones); end
    endtask

    task automatic test_reset_mid();
        int dones;
        load_unit_clause();
        start_clause(8'h04);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (ifc.mem_en !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0)
            begin errors++; $display("FAIL rstmid_ctrl: got en=%b busy=%b done=%b exp 0 0 0", ifc.mem_en, ifc.busy, ifc.done); end
        checks++; if (ifc.status !== 2'b00 || ifc.unit_lit !== 8'h00)
            begin errors++; $display("FAIL rstmid_result: got %b/%h exp 00/00", ifc.status, ifc.unit_lit); end
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ifc.done === 1'b1 || ifc.busy === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles exp 0", dones); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'h00;
            alog[i] = 8'h00;
        end
        ifc.start       = 1'b0;
        ifc.clause_addr = 8'h00;
        ifc.assign_def  = '0;
        ifc.assign_val  = '0;
        test_reset();
        test_unit();
        test_sat();
        test_conflict();
        test_wrap_maxlen();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
